// File: rtl/qed_pkg.sv
// Shared opcodes, constants, state encoding and the duplicate-mode operand
// remap for the EDDI-V QED issue stage.
package qed_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_NOP = 7'b1111111;

  localparam logic [31:0] QED_NOP = 32'h0000007F;

  localparam int unsigned SHADOW_BIT   = 4;
  localparam int unsigned MEM_HALF_BIT = 30;
  localparam int unsigned RD_LSB       = 7;
  localparam int unsigned RS1_LSB      = 15;
  localparam int unsigned RS2_LSB      = 20;

  typedef enum logic {
    ORIG = 1'b0,
    DUP  = 1'b1
  } qed_state_t;

  // Move register operands into the shadow half (x16..x31) and memory
  // accesses into the upper address half; rs1 of loads/stores is left as x0.
  function automatic logic [31:0] dup_transform(input logic [31:0] inst);
    logic [31:0] t;
    t = inst;
    case (inst[6:0])
      OP_R: begin
        t[RD_LSB + SHADOW_BIT]  = 1'b1;
        t[RS1_LSB + SHADOW_BIT] = 1'b1;
        t[RS2_LSB + SHADOW_BIT] = 1'b1;
      end
      OP_I: begin
        t[RD_LSB + SHADOW_BIT]  = 1'b1;
        t[RS1_LSB + SHADOW_BIT] = 1'b1;
      end
      OP_LW: begin
        t[RD_LSB + SHADOW_BIT] = 1'b1;
        t[MEM_HALF_BIT]        = 1'b1;
      end
      OP_SW: begin
        t[RS2_LSB + SHADOW_BIT] = 1'b1;
        t[MEM_HALF_BIT]         = 1'b1;
      end
      default: t = inst;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/qed_inst_buffer.sv
// Circular record of original instructions awaiting duplicate replay.
// Read data is the entry at the read pointer (show-ahead).
module qed_inst_buffer
  import qed_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_x,
  input  logic              push,
  input  logic              pop,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/qed_dup_issue.sv
// QED issue stage: forwards and records originals in ORIG, replays the
// recorded stream with shadow-remapped operands in DUP.
module qed_dup_issue
  import qed_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic [31:0] ifu_qed_instruction,
  input  logic        exec_dup,
  input  logic        stall_IF,
  output logic [31:0] qed_instruction,
  output logic        qed_vld_out,
  output logic        qed_stall_fetch,
  output logic        qed_mode,
  output logic        qed_ready
);

  qed_state_t      state;
  qed_state_t      state_nx;
  logic [31:0]     head;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] count_nx;
  logic            in_orig;
  logic            dup_req;
  logic            go_dup;
  logic            accept;
  logic            pop;
  logic            last_pop;
  logic [31:0]     inst_nx;
  logic            vld_nx;
  logic            ready_nx;

  assign in_orig  = (state == ORIG);
  assign dup_req  = exec_dup & ~empty;
  assign go_dup   = in_orig & ~stall_IF & (dup_req | full);
  assign accept   = in_orig & ~stall_IF & ~dup_req & ~full
                  & (ifu_qed_instruction[6:0] != OP_NOP);
  assign pop      = ~in_orig & ~stall_IF;
  assign last_pop = pop & (count == (ADDR_W+1)'(1));

  qed_inst_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .reset_x (reset_x),
    .push    (accept),
    .pop     (pop),
    .wdata   (ifu_qed_instruction),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      state <= ORIG;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ORIG:    if (go_dup)   state_nx = DUP;
      DUP:     if (last_pop) state_nx = ORIG;
      default: state_nx = ORIG;
    endcase
  end

  always_comb begin
    inst_nx  = QED_NOP;
    vld_nx   = 1'b0;
    count_nx = count;
    if (accept) begin
      inst_nx  = ifu_qed_instruction;
      vld_nx   = 1'b1;
      count_nx = count + 1'b1;
    end else if (pop) begin
      inst_nx  = dup_transform(head);
      vld_nx   = 1'b1;
      count_nx = count - 1'b1;
    end
    ready_nx = (state_nx == ORIG) && (count_nx == '0);
  end

  // Output register only loads when fetch is not stalled, so a stall holds it.
  always_ff @(posedge clk) begin
    if (!reset_x) begin
      qed_instruction <= QED_NOP;
      qed_vld_out     <= 1'b0;
      qed_ready       <= 1'b1;
    end else if (!stall_IF) begin
      qed_instruction <= inst_nx;
      qed_vld_out     <= vld_nx;
      qed_ready       <= ready_nx;
    end
  end

  assign qed_mode        = (state == DUP);
  assign qed_stall_fetch = stall_IF | ~in_orig | (in_orig & full) | (in_orig & dup_req);

endmodule

// File: doc/qed_dup_issue.md
# qed_dup_issue

Issues the constrained instruction stream into the ridecore fetch path for EDDI-V QED self-checking. In original mode it forwards each accepted instruction unchanged and records it. In duplicate mode it replays the recorded instructions with register and memory operands remapped to the shadow half. It sits directly downstream of the instruction constraint stage and upstream of the fetch/decode input mux.

## Interface
- `DEPTH`, default 16: recorded-instruction buffer entries; must be a power of two, at least 2.
- `ADDR_W`, default 4: log2(`DEPTH`).
- `clk`  in  1: the single clock.
- `reset_x`  in  1: synchronous, active-low reset.
- `ifu_qed_instruction`  in  32: constrained instruction; opcode `7'b1111111` is NOP (no instruction).
- `exec_dup`  in  1: request to enter duplicate mode.
- `stall_IF`  in  1: fetch backpressure; while high, the block freezes.
- `qed_instruction`  out  32: instruction issued to fetch (registered).
- `qed_vld_out`  out  1: `qed_instruction` is a real instruction.
- `qed_stall_fetch`  out  1: upstream input is not being consumed this cycle (combinational).
- `qed_mode`  out  1: 0 = ORIG, 1 = DUP (registered).
- `qed_ready`  out  1: registered; high when in ORIG and the buffer is empty, i.e. the check point where shadow registers must equal originals.

## Operation
- State machine has two states, ORIG and DUP. Reset state is ORIG.
- Buffer: circular, `DEPTH` entries, with write pointer, read pointer and occupancy counter (`ADDR_W+1` bits). Pointers wrap modulo `DEPTH`.
- Accept: in ORIG with `stall_IF`=0, no dup request, not full, and input opcode not NOP.
  - The instruction is forwarded unchanged with `qed_vld_out`=1.
  - It is written at the write pointer; the counter increments.
- ORIG with a NOP input and no stall: output the NOP constant `32'h0000007F` with `qed_vld_out`=0. Nothing is stored.
- Transition ORIG→DUP (next cycle) when `stall_IF`=0 and either:
  - `exec_dup`=1 and count≠0, or
  - count==`DEPTH` (forced).
  - The input in that cycle is not consumed; `qed_stall_fetch`=1 and a NOP is issued.
- `exec_dup` with count==0 is ignored.
- DUP with `stall_IF`=0: pop the entry at the read pointer and issue its transform with `qed_vld_out`=1. The counter decrements. The pop that empties the buffer returns the machine to ORIG next cycle.
- Duplicate transform (opcode-decoded):
  - R-type (`0110011`): set bit 4 of rd, rs1 and rs2.
  - I-type (`0010011`): set bit 4 of rd and rs1.
  - LW (`0000011`): set bit 4 of rd; set bit 30 (upper memory half); rs1 stays 0.
  - SW (`0100011`): set bit 4 of rs2; set bit 30; rs1 stays 0.
  - Any other opcode: pass unchanged.
- `qed_stall_fetch` = `stall_IF` | DUP | (ORIG & count==`DEPTH`) | (ORIG & `exec_dup` & count≠0).
- `qed_ready` is high in ORIG when the updated count is 0.

## Timing
- Reset values:
  - `qed_instruction` = `32'h0000007F`; `qed_vld_out` = 0; `qed_mode` = 0; `qed_ready` = 1.
  - Buffer count and both pointers are 0. Buffer contents are don't-care.
- Latency: an instruction accepted in cycle N appears on `qed_instruction` in N+1.
- A duplicate popped in cycle M appears in M+1.
- `stall_IF`=1 holds all registered outputs, pointers, count and state for that cycle. No push, no pop, no transition.
- Push and pop never occur in the same cycle: pushes happen only in ORIG, pops only in DUP.
- Reset asserted mid-DUP discards the buffer. In the next cycle all outputs take their reset values.
- A full buffer (`DEPTH` originals) forces DUP after exactly `DEPTH` accepts. DUP lasts exactly `DEPTH` unstalled cycles.

## Structure
- Package `qed_pkg` holds:
  - opcode constants (R, I, LW, SW, NOP);
  - the `QED_NOP` instruction constant;
  - the state enum {ORIG, DUP};
  - the shadow-bit index (4) and memory-half bit (30).
- Sub-module `qed_inst_buffer`: parameterized circular FIFO with push, pop, full, empty and count. The transform and state machine live in the top module.

## Test plan
- ADD x1,x2,x3 (`32'h003100B3`) accepted, then `exec_dup` → cycle+1 outputs `32'h003100B3`; DUP outputs `32'h013908B3`; then `qed_ready`=1.
- LW x5,4(x0) (`32'h00402283`) then `exec_dup` → duplicate is `32'h40402A83`.
- 16 consecutive ADDI inputs with `exec_dup`=0 → forced DUP; 16 transformed replays in order; pointers wrap to 0.
- `stall_IF` held for 3 cycles mid-DUP → outputs and count frozen; replay resumes with the same entry.
- `exec_dup`=1 with empty buffer and NOP inputs → stays ORIG, `qed_vld_out`=0, `qed_stall_fetch`=0.
- `reset_x`=0 in the second DUP cycle → next cycle the NOP constant, `qed_mode`=0, `qed_ready`=1, count 0.
